sha256d_round_sequencer: RTL and testbench
==========================================

Name: sha256d_round_sequencer

Overview:
- Controller for the SHA-256 round datapath (a–h registers, W shift register, t1/t2 logic).
- Sequences the double hash of an 80-byte mining header as three 64-round passes:
  - block 0: header words 0–15
  - block 1: header tail plus padding
  - block 2: first digest plus fixed padding
- Owns the chaining value H (h1..h8), performs the feed-forward add after each pass, buffers host message words, and drives select/control/block/K index to the datapath.

Parameters:
- WORDS, 16, message words buffered per block.
- LAST_SEL, 65, final select value of a pass (select runs 0..LAST_SEL).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a new double hash; ignored unless idle.
- busy  out  1  high from the accepted start until digest_valid.
- msg_data  in  32  host message word, word 0 of a block first.
- msg_valid  in  1  msg_data valid.
- msg_ready  out  1  sequencer accepts msg_data this cycle.
- state_in  in  256  datapath {a,b,c,d,e,f,g,h}, a in [255:224].
- select  out  7  datapath round counter.
- control  out  1  datapath load of a–h from h1..h8.
- block  out  2  pass number 0/1/2 to datapath.
- k_addr  out  6  K ROM index.
- message_in  out  32  buffered host word for the current select.
- message_hash  out  32  second-pass message word.
- h_out  out  256  {h1..h8} chaining value to datapath, h1 in [255:224].
- digest  out  256  final SHA-256d result, held until next start.
- digest_valid  out  1  one-cycle pulse when digest updates.

Behaviour:
- Reset: all outputs 0 except h_out = IV {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}.
  - State returns to IDLE, word buffer count 0.
  - Reset mid-pass aborts with no digest_valid.
- States IDLE -> LOAD -> RUN -> ADD -> (LOAD | RUN | DONE) -> IDLE.
- IDLE:
  - start=1 sets busy, block=0, h_out=IV, goes to LOAD.
  - start in any other state is ignored.
- LOAD (blocks 0, 1 only):
  - msg_ready=1 while count<WORDS.
  - Each msg_valid&msg_ready cycle writes buf[count], then count++.
  - count==WORDS moves to RUN with select=0. msg_ready is low in the transition cycle.
  - msg_valid may drop at any time; LOAD simply waits.
- RUN:
  - select increments by 1 each cycle from 0 to LAST_SEL, with no stalls.
  - control = 1 only at select==0.
  - k_addr = select-1 for select 1..64, else 0.
  - message_in = buf[select] for select<16, else 0.
  - message_hash (block 2 only, else 0):
    - select 0..7: mid word select, where mid word 0 = mid[255:224].
    - select 8: 80000000.
    - select 9..14: 0.
    - select 15: 00000100.
  - After select==LAST_SEL, go to ADD. select returns to 0 outside RUN.
- ADD (one cycle): h_i <= h_i + corresponding state_in word, each mod 2^32 with the carry discarded. Next action depends on block:
  - block 0: block=1, count=0, go to LOAD.
  - block 1: mid <= new H, h_out <= IV, block=2, go to RUN (no LOAD).
  - block 2: digest <= new H, go to DONE.
- DONE (one cycle): digest_valid=1, busy drops the following cycle, block=0, go to IDLE.
- Latency with msg_valid held high: start accepted at cycle 0, digest_valid at cycle 16+66+1+16+66+1+66+1+1 = 234.
- block and h_out are stable throughout RUN.
- buf is not rewritten during RUN.

Test Plan:
- Reset values: assert rst_n=0 mid-RUN.
  - Required: select=0, busy=0, msg_ready=0, digest_valid=0, h_out=IV immediately.
  - After release, IDLE.
- Handshake: start, msg_valid toggled 1/0 each cycle with words 0..15.
  - Required: exactly 16 accepted, in order.
  - Required: message_in equals word s at select s; select reaches 0 only after the 16th acceptance.
- Select sweep with stub datapath:
  - Required: select 0..65 contiguous, control high only at select 0, k_addr 0..63 at select 1..64, block stepping 0,1,2.
  - Required: no LOAD phase (msg_ready stays 0) before block 2.
- Feed-forward wrap:
  - state_in = all FFFFFFFF after block 0 -> h1=6a09e666, h8=5be0cd18.
  - state_in all 0 -> H unchanged.
- Second-pass words: force mid = {00000001..00000008}.
  - Required message_hash: 00000001..00000008 at select 0..7, 80000000 at 8, 0 at 9..14, 00000100 at 15.
- End-to-end with the real datapath: Bitcoin genesis header (80 bytes plus padding words supplied).
  - Required: digest = 6fe28c0a b6f1b372 c1a6a246 ae63f74f 931e8365 e15a089c 68d61900 00000000 (LE), byte-reversed.
  - Required: digest_valid a single pulse at cycle 234; start during busy has no effect.

Source files
------------

// File: rtl/sha256d_round_sequencer_if.sv
// rtl/sha256d_round_sequencer_if.sv - host-side start, message stream and digest bundle
interface sha256d_round_sequencer_if;
  logic         start;
  logic         busy;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic [255:0] digest;
  logic         digest_valid;

  modport master (
    output start, msg_data, msg_valid,
    input  busy, msg_ready, digest, digest_valid
  );

  modport slave (
    input  start, msg_data, msg_valid,
    output busy, msg_ready, digest, digest_valid
  );
endinterface

// File: rtl/sha256d_round_sequencer.sv
// rtl/sha256d_round_sequencer.sv - sequences three SHA-256 passes for a double hash of an 80-byte header
module sha256d_round_sequencer #(
  parameter int WORDS    = 16,
  parameter int LAST_SEL = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha256d_round_sequencer_if.slave host,
  input  logic [255:0]             i_state_in,
  output logic [6:0]               o_select,
  output logic                     o_control,
  output logic [1:0]               o_block,
  output logic [5:0]               o_k_addr,
  output logic [31:0]              o_message_in,
  output logic [31:0]              o_message_hash,
  output logic [255:0]             o_h_out
);
  localparam int              CW        = $clog2(WORDS + 1);
  localparam int              IW        = $clog2(WORDS);
  localparam logic [CW-1:0]   LAST_WORD = CW'(WORDS - 1);
  localparam logic [6:0]      SEL_LAST  = 7'(LAST_SEL);
  localparam logic [6:0]      SEL_WORDS = 7'(WORDS);
  localparam logic [255:0]    IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ADD, S_DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_buf [WORDS];
  logic [6:0]     r_select;
  logic           r_control;
  logic [1:0]     r_block;
  logic [255:0]   r_h;
  logic [255:0]   r_mid;
  logic [255:0]   r_digest;
  logic           r_digest_valid;
  logic           r_busy;
  logic           r_msg_ready;

  logic [255:0]   w_sum;
  logic [31:0]    w_mid_word;
  logic           w_accept;

  assign w_accept = (r_state == S_LOAD) && r_msg_ready && host.msg_valid;

  // Feed-forward: eight independent 32-bit adds, carries never cross word boundaries.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i*32 +: 32] = r_h[i*32 +: 32] + i_state_in[i*32 +: 32];
    end
  end

  always_comb begin
    w_mid_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_select[2:0] == 3'(i)) w_mid_word = r_mid[255 - 32*i -: 32];
    end
  end

  always_comb begin
    o_k_addr       = '0;
    o_message_in   = '0;
    o_message_hash = '0;
    if (r_state == S_RUN) begin
      // select 64 wraps to 63 in six bits, so one subtract covers rounds 1..64.
      if (r_select != 7'd0 && r_select <= 7'd64) o_k_addr = r_select[5:0] - 6'd1;
      if (r_select < SEL_WORDS) o_message_in = r_buf[r_select[IW-1:0]];
      if (r_block == 2'd2) begin
        if (r_select < 7'd8)        o_message_hash = w_mid_word;
        else if (r_select == 7'd8)  o_message_hash = 32'h8000_0000;
        else if (r_select == 7'd15) o_message_hash = 32'h0000_0100;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_count[IW-1:0]] <= host.msg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_select       <= '0;
      r_control      <= 1'b0;
      r_block        <= '0;
      r_h            <= IV;
      r_mid          <= '0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_msg_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (host.start) begin
            r_busy      <= 1'b1;
            r_block     <= 2'd0;
            r_h         <= IV;
            r_count     <= '0;
            r_msg_ready <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST_WORD) begin
              r_msg_ready <= 1'b0;
              r_select    <= '0;
              r_control   <= 1'b1;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_control <= 1'b0;
          if (r_select == SEL_LAST) begin
            r_select <= '0;
            r_state  <= S_ADD;
          end else begin
            r_select <= r_select + 7'd1;
          end
        end
        S_ADD: begin
          r_h <= w_sum;
          case (r_block)
            2'd0: begin
              r_block     <= 2'd1;
              r_count     <= '0;
              r_msg_ready <= 1'b1;
              r_state     <= S_LOAD;
            end
            2'd1: begin
              // Second hash restarts from IV over the first digest; no host words needed.
              r_mid     <= w_sum;
              r_h       <= IV;
              r_block   <= 2'd2;
              r_select  <= '0;
              r_control <= 1'b1;
              r_state   <= S_RUN;
            end
            default: begin
              r_digest       <= w_sum;
              r_digest_valid <= 1'b1;
              r_state        <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          r_digest_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_block        <= 2'd0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_select          = r_select;
  assign o_control         = r_control;
  assign o_block           = r_block;
  assign o_h_out           = r_h;
  assign host.busy         = r_busy;
  assign host.msg_ready    = r_msg_ready;
  assign host.digest       = r_digest;
  assign host.digest_valid = r_digest_valid;
endmodule

// File: tb/tb_sha256d_round_sequencer.sv
// tb/tb_sha256d_round_sequencer.sv - randomized bench with a SHA-256d reference and a behavioural round datapath
module tb_sha256d_round_sequencer;
  localparam logic [255:0] IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] GEN = 256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
  localparam logic [639:0] GEN_HDR = {
    32'h01000000, 256'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256d_round_sequencer_if hif();
  logic [255:0] state_in;
  logic [6:0]   sel;
  logic         ctl;
  logic [1:0]   blk;
  logic [5:0]   kad;
  logic [31:0]  min;
  logic [31:0]  mhash;
  logic [255:0] hout;

  sha256d_round_sequencer #(.WORDS(16), .LAST_SEL(65)) dut (
    .clk(clk), .rst_n(rst_n), .host(hif), .i_state_in(state_in),
    .o_select(sel), .o_control(ctl), .o_block(blk), .o_k_addr(kad),
    .o_message_in(min), .o_message_hash(mhash), .o_h_out(hout));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  function automatic logic [255:0] round_fn(input logic [255:0] v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sub8(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk_in);
    logic [31:0]  w [64];
    logic [255:0] v;
    for (int t = 0; t < 16; t++) w[t] = blk_in[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    v = h;
    for (int t = 0; t < 64; t++) v = round_fn(v, K[t], w[t]);
    return add8(h, v);
  endfunction

  task automatic ref_sha256d(input logic [639:0] hdr, output logic [255:0] c0,
                             output logic [255:0] mid, output logic [255:0] dig);
    c0  = compress(IV, hdr[639:128]);
    mid = compress(c0, {hdr[127:0], 32'h80000000, 288'h0, 64'd640});
    dig = compress(IV, {mid, 32'h80000000, 160'h0, 64'd256});
  endtask

  function automatic logic [31:0] exp_hash_word(input logic [255:0] mid, input int s);
    if (s < 8)   return mid[255 - 32*s -: 32];
    if (s == 8)  return 32'h80000000;
    if (s == 15) return 32'h00000100;
    return 32'h0;
  endfunction

  // Round datapath: loads a-h at control, runs round t at select t+1, builds W on the fly.
  logic         use_dp;
  logic [255:0] stub [4];
  logic [255:0] dp_state;
  logic [31:0]  dp_w [64];
  logic [31:0]  dp_word;
  int           dp_s;
  assign dp_word  = (blk == 2'd2) ? mhash : min;
  assign dp_s     = int'(sel);
  assign state_in = use_dp ? dp_state : stub[blk];

  always @(posedge clk) begin
    if (ctl) begin
      dp_state <= hout;
      dp_w[0]  <= dp_word;
    end else if (dp_s >= 1 && dp_s <= 64) begin
      dp_state <= round_fn(dp_state, K[dp_s-1], dp_w[dp_s-1]);
      if (dp_s < 16) dp_w[dp_s] <= dp_word;
      else if (dp_s < 64) dp_w[dp_s] <= ssig1(dp_w[dp_s-2]) + dp_w[dp_s-7] + ssig0(dp_w[dp_s-15]) + dp_w[dp_s-16];
    end
  end

  logic [31:0]  mw [32];
  logic [639:0] hdr;

  task automatic words_from_hdr();
    for (int i = 0; i < 20; i++) mw[i] = hdr[639 - 32*i -: 32];
    mw[20] = 32'h80000000;
    for (int i = 21; i < 31; i++) mw[i] = 32'h0;
    mw[31] = 32'h00000280;
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid
  task automatic run_hash(input int mode, input bit start_dup);
    logic [255:0] hexp [3];
    logic [255:0] c0, mid, dig;
    logic [31:0]  exp_min;
    int cyc, pass, es, acc, idx, dv_cyc;
    if (use_dp) ref_sha256d(hdr, c0, mid, dig);
    else begin
      c0  = add8(IV, stub[0]);
      mid = add8(c0, stub[1]);
      dig = add8(IV, stub[2]);
    end
    hexp[0] = IV; hexp[1] = c0; hexp[2] = IV;
    cyc = 0; pass = 0; es = -1; acc = 0; idx = 0; dv_cyc = -1;
    @(negedge clk);
    hif.start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      hif.start = start_dup && (cyc == 50);
      if (es < 0 && pass < 3 && ctl) begin
        es = 0;
        chk("accepted_words", acc, (pass == 0) ? 16 : 32);
      end
      if (es >= 0) begin
        exp_min = (es < 16) ? mw[((pass == 0) ? 0 : 16) + es] : 32'h0;
        chk("select", sel, es);
        chk("control", ctl, es == 0);
        chk("k_addr", kad, (es >= 1 && es <= 64) ? es - 1 : 0);
        chk("block", blk, pass);
        chk("h_out", hout, hexp[pass]);
        chk("msg_ready_run", hif.msg_ready, 0);
        chk("message_in", min, exp_min);
        chk("message_hash", mhash, (pass == 2) ? exp_hash_word(mid, es) : 32'h0);
        if (es == 65) begin
          es = -1;
          pass++;
          if (pass == 3) dv_cyc = cyc + 2;
        end else es++;
      end else begin
        chk("select_idle", sel, 0);
        chk("control_idle", ctl, 0);
        chk("k_addr_idle", kad, 0);
        chk("message_in_idle", min, 0);
        chk("message_hash_idle", mhash, 0);
        if (pass == 2) chk("no_load_b2", hif.msg_ready, 0);
      end
      chk("digest_valid", hif.digest_valid, cyc == dv_cyc);
      chk("busy", hif.busy, dv_cyc < 0 || cyc <= dv_cyc);
      if (cyc == dv_cyc) begin
        chk("digest", hif.digest, dig);
        if (mode == 0) chk("latency", cyc, 234);
      end
      if (dv_cyc >= 0 && cyc == dv_cyc + 2) begin
        chk("digest_hold", hif.digest, dig);
        break;
      end
      if (cyc >= 3000) begin
        chk("timeout_passes", pass, 3);
        break;
      end
      hif.msg_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      hif.msg_data  = mw[(idx < 32) ? idx : 31];
      if (hif.msg_valid && hif.msg_ready) begin
        acc++;
        idx++;
      end
    end
    hif.msg_valid = 1'b0;
    hif.start     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_select"}, sel, 0);
    chk({tag, "_busy"}, hif.busy, 0);
    chk({tag, "_msg_ready"}, hif.msg_ready, 0);
    chk({tag, "_digest_valid"}, hif.digest_valid, 0);
    chk({tag, "_h_out"}, hout, IV);
    chk({tag, "_block"}, blk, 0);
    chk({tag, "_control"}, ctl, 0);
    chk({tag, "_digest"}, hif.digest, 0);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    hif.start = 1'b0; hif.msg_valid = 1'b0; hif.msg_data = '0;
    use_dp = 1'b0;
    for (int i = 0; i < 4; i++) stub[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Toggled valid, all-ones wrap after block 0, mid forced to 1..8, zero state leaves H unchanged.
    for (int i = 0; i < 32; i++) mw[i] = $urandom;
    stub[0] = {8{32'hffffffff}};
    stub[1] = sub8({32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, add8(IV, stub[0]));
    stub[2] = '0;
    run_hash(1, 1'b0);

    // Genesis block through the behavioural datapath, with a start pulse while busy.
    use_dp = 1'b1;
    hdr = GEN_HDR;
    words_from_hdr();
    run_hash(0, 1'b1);
    chk("genesis_digest", hif.digest, GEN);

    // Reset in the middle of a RUN pass.
    @(negedge clk);
    hif.start = 1'b1;
    budget = 0;
    @(negedge clk);
    hif.start = 1'b0;
    hif.msg_valid = 1'b1;
    while (sel != 7'd20 && budget < 200) begin
      hif.msg_data = $urandom;
      @(negedge clk);
      budget++;
    end
    chk("reach_mid_run", sel, 20);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    hif.msg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", hif.busy, 0);
      chk("post_rst_msg_ready", hif.msg_ready, 0);
      chk("post_rst_dv", hif.digest_valid, 0);
    end

    for (int r = 0; r < 3; r++) begin
      use_dp = 1'b1;
      for (int i = 0; i < 20; i++) hdr[639 - 32*i -: 32] = $urandom;
      words_from_hdr();
      run_hash(2, 1'b0);
      use_dp = 1'b0;
      for (int i = 0; i < 32; i++) mw[i] = $urandom;
      for (int b = 0; b < 3; b++)
        for (int i = 0; i < 8; i++) stub[b][i*32 +: 32] = $urandom;
      run_hash(2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
